// File: rtl/seg_pkg.sv
// seg_pkg: glyph table, digit count and FSM states shared by the scan capture path.
package seg_pkg;
  localparam int DIGITS = 8;
  // Active-high a..g patterns, index = hex value.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: decodes an active-low seven-segment pattern into a hex nibble and legal flag.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);
  logic [6:0] pat;
  assign pat = ~seg;
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pat == GLYPHS[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
  end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples the seg/an scan bus, debounces each digit dwell and publishes the recovered 32-bit word.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [7:0]  an,
  output logic [31:0] value,
  output logic        frame_valid,
  output logic        digit_err,
  output logic [7:0]  frame_count
);
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  state_t state, nxt;
  logic [14:0] pair_q;
  logic [3:0] cnt, cnt_nxt, nib;
  logic [31:0] shadow, merged;
  logic [7:0] seen, sel;
  logic valid, same, acc, relatch, legal, full;
  seg7_to_hex u_dec (
    .seg    (seg),
    .nibble (nib),
    .legal  (legal)
  );
  assign sel   = ~an;
  assign valid = $onehot(sel);
  assign same  = valid && ({an, seg} == pair_q);
  assign full  = &(seen | sel);
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    relatch = 1'b0;
    acc     = 1'b0;
    case (state)
      WAIT:
        if (valid) begin
          relatch = 1'b1;
          cnt_nxt = 4'd1;
          acc     = (STABLE == 4'd1);
          nxt     = (STABLE == 4'd1) ? HELD : SETTLE;
        end
      SETTLE:
        if (!valid) nxt = WAIT;
        else if (same) begin
          acc     = (cnt + 4'd1 >= STABLE);
          cnt_nxt = acc ? STABLE : cnt + 4'd1;
          nxt     = acc ? HELD : SETTLE;
        end else begin
          relatch = 1'b1;
          cnt_nxt = 4'd1;
        end
      HELD:
        if (!valid) nxt = WAIT;
        else if (!same) begin
          relatch = 1'b1;
          cnt_nxt = 4'd1;
          acc     = (STABLE == 4'd1);
          nxt     = (STABLE == 4'd1) ? HELD : SETTLE;
        end
      default: nxt = WAIT;
    endcase
  end
  // Shadow with the digit being accepted this cycle already merged in.
  always_comb begin
    merged = shadow;
    for (int i = 0; i < DIGITS; i++)
      if (sel[i]) merged[4*i +: 4] = nib;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= WAIT;
      pair_q      <= '0;
      cnt         <= '0;
      shadow      <= '0;
      seen        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      digit_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_nxt;
      frame_valid <= acc && legal && full;
      digit_err   <= acc && !legal;
      if (relatch) pair_q <= {an, seg};
      if (acc && legal) begin
        shadow <= merged;
        seen   <= full ? 8'h00 : (seen | sel);
        if (full) begin
          value       <= merged;
          frame_count <= frame_count + 8'd1;
        end
      end
    end
endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Capture block on the receiving end of the multiplexed seven-segment scan bus (seg/an) driven by the display path. Each clock it samples the scan bus, recovers the hex nibble shown on each digit, and after all eight digits have been seen it publishes the reconstructed 32-bit display word. It is used as a self-check monitor in simulation and for on-board loopback, so a bench can compare the recovered word against the word the display path was given.

## Interface
Parameters:
- STABLE_CYCLES, 2: consecutive identical samples required before a digit is accepted; legal range 1..15.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- seg  in  7  segment lines, active-low; seg[0]=a … seg[6]=g.
- an  in  8  anode selects, active-low; an[i]=0 selects digit i.
- value  out  32  last complete frame; digit i occupies value[4i+3:4i]; reset 32'h0.
- frame_valid  out  1  one-cycle pulse when value is updated; reset 0.
- digit_err  out  1  one-cycle pulse when an accepted dwell holds a segment pattern that is not a legal hex glyph; reset 0.
- frame_count  out  8  completed frames, wraps 255→0; reset 0.

## Operation
- A sample is valid when exactly one bit of an is 0. Zero or several low anodes make the sample invalid.
- Glyphs use the standard active-high a..g patterns before inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other pattern is illegal.
- FSM, reset state WAIT:
  - WAIT: on a valid sample, latch {an,seg}, set cnt=1, go to SETTLE. If STABLE_CYCLES=1, accept immediately and go to HELD.
  - SETTLE: if the sample equals the latched pair, increment cnt; when cnt reaches STABLE_CYCLES, accept and go to HELD. If the sample is valid but different, relatch and set cnt=1. If the sample is invalid, go to WAIT.
  - HELD: stay while the sample equals the latched pair, so one dwell produces at most one accept. If the sample is valid but different, relatch, set cnt=1 and go to SETTLE (or accept directly if STABLE_CYCLES=1). If the sample is invalid, go to WAIT.
- Accept, legal glyph: write the nibble into shadow digit i and set seen[i].
- Accept, illegal glyph: pulse digit_err; shadow and seen are unchanged.
- Frame completion: the accept that makes seen==8'hFF (including the accept itself) loads value from the shadow, with the just-accepted nibble merged in. The same edge pulses frame_valid, increments frame_count and clears seen.
- Repeated digits before completion overwrite the shadow nibble (the newest value wins). Scan order is irrelevant.

## Timing
- Inputs come from the same clock domain; no synchronizer.
- If the pair first appears at edge k, the accept happens at edge k+STABLE_CYCLES−1. value, frame_valid and digit_err change on that edge and are registered outputs.
- frame_valid and digit_err are high for exactly one cycle. They are never both high, because an illegal accept cannot complete a frame.
- Async reset mid-frame clears seen, shadow, all outputs and cnt, and returns the FSM to WAIT. The first frame after reset needs all eight digits again.
- cnt saturates at STABLE_CYCLES. It is 4 bits wide.

## Structure
- Package seg_pkg holds the 16 glyph constants, the digit count (8) and the FSM state enum.
- Sub-module seg7_to_hex is combinational: input 7-bit active-low seg; outputs 4-bit nibble and legal flag. It is shared with any future display checker.
- The top module contains the FSM, the stability counter, the shadow/seen registers and the output registers.

## Test plan
- Scan digits 0..7 showing 8,7,6,5,4,3,2,1, each held 3 cycles, STABLE_CYCLES=2 → one frame_valid pulse, value=32'h12345678, frame_count=1.
- Hold digit 3 showing glyph "A" for 20 cycles inside a full scan → exactly one accept; value[15:12]=4'hA; no duplicate frame.
- Present seg=7'b1010101 on digit 2 for 3 cycles → digit_err pulses once; seen[2] stays 0; the frame does not complete until digit 2 shows a legal glyph.
- Single-cycle glitch (a different digit for 1 cycle) and a 2-cycle period with an=8'hFF / an=8'h00 → no accept; FSM returns to WAIT; value is unchanged.
- Assert rst after 5 digits have been accepted, release it, then scan all 8 digits showing F..8 → frame_valid only after the full post-reset scan; value=32'h89ABCDEF.
- Run 256 back-to-back frames → frame_count wraps to 0; frame_valid pulses 256 times.
